// File: rtl/filter_bist_pkg.sv
// filter_bist_pkg
//   Shared types and constants for the filter self-test driver:
//   FSM state encoding, LFSR / MISR polynomials, shift-register mode
//   encoding and single-step helper functions for both register modes.
package filter_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        MODE_LFSR = 1'b0,
        MODE_MISR = 1'b1
    } sr_mode_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    // Galois right-shift LFSR step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // Left-shift MISR step folding in a 4-bit response word.
    function automatic logic [15:0] misr_step(input logic [15:0] s,
                                              input logic [3:0]  d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {12'h000, d};
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// bist_lfsr16
//   16-bit shift register used either as a free-running pattern LFSR
//   (mode=MODE_LFSR) or as a 4-input MISR (mode=MODE_MISR).
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, loads seed
//   mode  - register function select
//   clr   - synchronous reload with seed (start of a new run)
//   en    - advance one step
//   seed  - reset / reload value
//   din   - parallel response input (MISR mode only)
//   q     - low OUT_W bits of the register
module bist_lfsr16
    import filter_bist_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  sr_mode_t         mode,
    input  logic             clr,
    input  logic             en,
    input  logic [15:0]      seed,
    input  logic [3:0]       din,
    output logic [OUT_W-1:0] q
);

    logic [15:0] sr_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr_q <= seed;
        end else if (en) begin
            sr_q <= (mode == MODE_MISR) ? misr_step(sr_q, din) : lfsr_step(sr_q);
        end
    end

    assign q = sr_q[OUT_W-1:0];

endmodule

// File: rtl/filter_bist.sv
// filter_bist
//   Self-test driver for the 4-in/4-out combinational filter. Drives an
//   all-zero settle phase of 2*HOLD cycles, then NPAT pseudo-random
//   patterns each held HOLD cycles, compacting the filter response into a
//   16-bit MISR on the last cycle of every hold window.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - run request, honoured in IDLE or DONE
//   a,b,c,d          - stimulus to filter (a = MSB)
//   w,x,y,z          - filter response (w = MSB)
//   busy             - run in progress
//   done             - run complete, signature valid
//   signature        - MISR contents
//   pat_cnt          - patterns sampled this run (saturates at 255)
module filter_bist
    import filter_bist_pkg::*;
#(
    parameter int          HOLD = 50,
    parameter int          NPAT = 100,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        w,
    input  logic        x,
    input  logic        y,
    input  logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [7:0]  pat_cnt
);

    // hold_cnt walks the cycles of one hold window; win_cnt counts windows
    // within the current phase (2 in ZERO, NPAT in RUN).
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int WW = $clog2(NPAT + 2);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [WW-1:0] NPAT_LAST = WW'(NPAT - 1);
    localparam logic [WW-1:0] ZERO_LAST = WW'(1);

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt;
    logic [WW-1:0]   win_cnt;
    logic [3:0]      lfsr_tap;
    logic [3:0]      stim;
    logic            accept, hold_last, zero_end, run_sample, run_end;

    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign hold_last  = (hold_cnt == HOLD_LAST);
    assign zero_end   = (state_q == ZERO) && hold_last && (win_cnt == ZERO_LAST);
    assign run_sample = (state_q == RUN) && hold_last;
    assign run_end    = run_sample && (win_cnt == NPAT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)    state_d = ZERO;
            ZERO:       if (zero_end) state_d = RUN;
            RUN:        if (run_end)  state_d = DONE;
            default:                  state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        stim = 4'b0000;
        case (state_q)
            ZERO: busy = 1'b1;
            RUN: begin
                busy = 1'b1;
                stim = lfsr_tap;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign {a, b, c, d} = stim;

    // Hold / window counters and the saturating pattern counter
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            hold_cnt <= '0;
            win_cnt  <= '0;
            pat_cnt  <= 8'd0;
        end else begin
            if ((state_q == ZERO) || (state_q == RUN)) begin
                if (hold_last) begin
                    hold_cnt <= '0;
                    // RUN window numbering restarts at the end of ZERO
                    win_cnt  <= zero_end ? '0 : win_cnt + 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
            if (run_sample && (pat_cnt != 8'hFF)) pat_cnt <= pat_cnt + 8'd1;
        end
    end

    bist_lfsr16 #(.OUT_W(4)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .mode (MODE_LFSR),
        .clr  (accept),
        .en   (run_sample),
        .seed (SEED),
        .din  (4'b0000),
        .q    (lfsr_tap)
    );

    bist_lfsr16 #(.OUT_W(16)) u_misr (
        .clk  (clk),
        .rst  (rst),
        .mode (MODE_MISR),
        .clr  (accept),
        .en   (run_sample),
        .seed (16'h0000),
        .din  ({w, x, y, z}),
        .q    (signature)
    );

endmodule

// File: tb/tb_filter_bist.sv
// tb_filter_bist
//   Four instances of filter_bist with different parameters and filters:
//   dut2 HOLD=2/NPAT=3 identity loopback (timing table), dut3 HOLD=1/NPAT=2
//   constant 1111 filter, dutd default parameters identity loopback, and
//   dutr HOLD=3/NPAT=300 with a random lookup-table filter.
module tb_filter_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference signature: walk the pattern sequence and fold each filter
    // response into the signature, straight from the register equations.
    function automatic logic [15:0] ref_sig(input int n, input logic [15:0] seed,
                                            input logic [3:0] tbl [16]);
        int unsigned s, sig;
        s = seed;
        sig = 0;
        for (int i = 0; i < n; i++) begin
            sig = ((sig * 2) % 65536) ^ ((sig >= 32768) ? 32'h1021 : 32'h0) ^ tbl[s % 16];
            s = (s % 2 == 1) ? ((s / 2) ^ 32'hB400) : (s / 2);
        end
        return sig[15:0];
    endfunction

    // ---------------- dut2: HOLD=2 NPAT=3 identity ----------------
    logic rst2, start2, busy2, done2;
    wire [3:0] s2;
    logic [15:0] sig2;
    logic [7:0]  pc2;
    filter_bist #(.HOLD(2), .NPAT(3), .SEED(16'hACE1)) dut2 (
        .clk(clk), .rst(rst2), .start(start2),
        .a(s2[3]), .b(s2[2]), .c(s2[1]), .d(s2[0]),
        .w(s2[3]), .x(s2[2]), .y(s2[1]), .z(s2[0]),
        .busy(busy2), .done(done2), .signature(sig2), .pat_cnt(pc2));

    // ---------------- dut3: HOLD=1 NPAT=2 constant 1111 ----------------
    logic rst3, start3, busy3, done3;
    wire [3:0] s3;
    logic [15:0] sig3;
    logic [7:0]  pc3;
    filter_bist #(.HOLD(1), .NPAT(2), .SEED(16'hACE1)) dut3 (
        .clk(clk), .rst(rst3), .start(start3),
        .a(s3[3]), .b(s3[2]), .c(s3[1]), .d(s3[0]),
        .w(1'b1), .x(1'b1), .y(1'b1), .z(1'b1),
        .busy(busy3), .done(done3), .signature(sig3), .pat_cnt(pc3));

    // ---------------- dutd: default parameters identity ----------------
    logic rstd, startd, busyd, doned;
    wire [3:0] sd;
    logic [15:0] sigd;
    logic [7:0]  pcd;
    filter_bist dutd (
        .clk(clk), .rst(rstd), .start(startd),
        .a(sd[3]), .b(sd[2]), .c(sd[1]), .d(sd[0]),
        .w(sd[3]), .x(sd[2]), .y(sd[1]), .z(sd[0]),
        .busy(busyd), .done(doned), .signature(sigd), .pat_cnt(pcd));

    // ---------------- dutr: HOLD=3 NPAT=300 random LUT filter ----------------
    logic rstr, startr, busyr, doner;
    wire [3:0] sr;
    wire [3:0] rsp_r;
    logic [3:0] lut [16];
    logic [15:0] sigr;
    logic [7:0]  pcr;
    assign rsp_r = lut[sr];
    filter_bist #(.HOLD(3), .NPAT(300), .SEED(16'h5A5A)) dutr (
        .clk(clk), .rst(rstr), .start(startr),
        .a(sr[3]), .b(sr[2]), .c(sr[1]), .d(sr[0]),
        .w(rsp_r[3]), .x(rsp_r[2]), .y(rsp_r[1]), .z(rsp_r[0]),
        .busy(busyr), .done(doner), .signature(sigr), .pat_cnt(pcr));

    // Timing table for dut2: start for cycle i and outputs seen in cycle i.
    typedef struct {
        logic       start;
        logic [3:0] abcd;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t vt [12];

    logic [3:0] ident [16];
    logic [3:0] ones  [16];

    // Walk the 12-cycle table on dut2. pulse adds ignored starts in ZERO
    // (cycle 2) and RUN (cycle 6); from_done means the run begins in DONE.
    task automatic run2(input bit pulse, input bit from_done, input string tag);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s cyc%0d abcd/busy/done", tag, i),
                {26'd0, s2, busy2, done2},
                {26'd0, vt[i].abcd, vt[i].busy, (i == 0) ? from_done : vt[i].done});
            start2 = vt[i].start | (pulse && (i == 2 || i == 6));
            @(posedge clk);
            @(negedge clk);
        end
        chk({tag, " signature"}, {16'd0, sig2}, 32'h000C);
        chk({tag, " pat_cnt"},   {24'd0, pc2},  32'd3);
    endtask

    int n;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ident[i] = 4'(i);
            ones[i]  = 4'hF;
            lut[i]   = 4'(i);
        end
        for (int i = 0; i < 12; i++) begin
            vt[i].start = (i == 0);
            vt[i].abcd  = 4'b0000;
            vt[i].busy  = (i >= 1 && i <= 10);
            vt[i].done  = (i == 11);
        end
        vt[5].abcd = 4'b0001; vt[6].abcd  = 4'b0001;
        vt[9].abcd = 4'b1000; vt[10].abcd = 4'b1000;

        // 1. Reset with start held high
        {rst2, rst3, rstd, rstr}         = 4'hF;
        {start2, start3, startd, startr} = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset dut2 abcd/busy/done", {26'd0, s2, busy2, done2}, 32'd0);
        chk("reset dut2 sig/pat", {8'd0, sig2, pc2}, 32'd0);
        chk("reset dut3 busy/done/sig", {15'd0, busy3, done3, sig3}, 32'd0);
        chk("reset dutd busy/done/sig", {15'd0, busyd, doned, sigd}, 32'd0);
        chk("reset dutr abcd/busy/done/pat", {18'd0, sr, busyr, doner, pcr}, 32'd0);
        {rst2, rst3, rstd, rstr}         = 4'h0;
        {start2, start3, startd, startr} = 4'h0;
        @(negedge clk);
        chk("idle after reset dut2", {26'd0, s2, busy2, done2}, 32'd0);

        // 2. Identity loopback timing
        run2(1'b0, 1'b0, "case2");
        // 5. start in DONE with ignored pulses in ZERO/RUN, then plain rerun
        run2(1'b1, 1'b1, "case5 pulsed");
        run2(1'b0, 1'b1, "case5 rerun");

        // 4. Reset mid-run at cycle 6
        start2 = 1'b1;
        @(posedge clk); @(negedge clk);
        start2 = 1'b0;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        chk("case4 cyc6 busy/abcd", {27'd0, busy2, s2}, {27'd0, 1'b1, 4'b0001});
        rst2 = 1'b1;
        @(posedge clk); @(negedge clk);
        rst2 = 1'b0;
        chk("case4 after rst abcd/busy/done", {26'd0, s2, busy2, done2}, 32'd0);
        chk("case4 after rst sig/pat", {8'd0, sig2, pc2}, 32'd0);
        @(negedge clk);
        chk("case4 stays idle", {26'd0, s2, busy2, done2}, 32'd0);
        run2(1'b0, 1'b0, "case4 fresh");

        // 3. Constant filter
        start3 = 1'b1;
        @(posedge clk); @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (busy3 && n < 100) begin n++; @(negedge clk); end
        chk("case3 busy cycles", n, 32'd4);
        chk("case3 done", {31'd0, done3}, 32'd1);
        chk("case3 signature", {16'd0, sig3}, {16'd0, ref_sig(2, 16'hACE1, ones)});
        chk("case3 pat_cnt", {24'd0, pc3}, 32'd2);

        // 6. Default parameters
        startd = 1'b1;
        @(posedge clk); @(negedge clk);
        startd = 1'b0;
        n = 0;
        while (busyd && n < 6000) begin n++; @(negedge clk); end
        chk("case6 busy cycles", n, 32'd5100);
        chk("case6 done", {31'd0, doned}, 32'd1);
        chk("case6 signature", {16'd0, sigd}, {16'd0, ref_sig(100, 16'hACE1, ident)});
        chk("case6 pat_cnt", {24'd0, pcd}, 32'd100);
        chk("case6 abcd in DONE", {28'd0, sd}, 32'd0);

        // Random lookup-table filters, NPAT past the pat_cnt saturation point
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) lut[i] = 4'($urandom_range(0, 15));
            startr = 1'b1;
            @(posedge clk); @(negedge clk);
            startr = 1'b0;
            chk($sformatf("rand%0d done cleared", r), {31'd0, doner}, 32'd0);
            n = 0;
            while (busyr && n < 2000) begin n++; @(negedge clk); end
            chk($sformatf("rand%0d busy cycles", r), n, 32'd906);
            chk($sformatf("rand%0d done", r), {31'd0, doner}, 32'd1);
            chk($sformatf("rand%0d pat_cnt saturated", r), {24'd0, pcr}, 32'd255);
            chk($sformatf("rand%0d signature", r), {16'd0, sigr},
                {16'd0, ref_sig(300, 16'h5A5A, lut)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
